btc_result_collector: RTL and testbench

Job sequencer and result buffer that sits directly upstream and downstream of the mining core. It accepts a job start nonce from the host over a valid/ready handshake and launches the core by toggling its asynchronous start line. It watches the core's done/found outputs and pushes every found nonce into a small FIFO. Optionally it resumes the search from found_nonce+1 until the nonce space is exhausted.

---
 rtl/btc_result_collector.sv | 229 ++++++++++++++++++++++
 tb/tb_btc_result_collector.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btc_result_collector.sv
// Job sequencer and found-nonce FIFO wrapped around the mining core.
// Optional per-result elapsed-cycle tagging: define BTC_COLLECTOR_ELAPSED_EN.
module btc_result_collector #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [31:0]                   job_nonce,
   input  logic                          job_resume,
   output logic                          core_start_a,
   output logic                          core_use_nonce_in,
   output logic [31:0]                   core_nonce_in,
   input  logic                          core_done,
   input  logic                          core_nonce_found_flag,
   input  logic [31:0]                   core_nonce_out,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [31:0]                   res_nonce,
   output logic [$clog2(FIFO_DEPTH):0]   res_level,
   output logic                          busy,
   output logic [CNT_W-1:0]              found_count,
`ifdef BTC_COLLECTOR_ELAPSED_EN
   output logic [31:0]                   res_cycles,
`endif
   output logic                          err_ack
);

   localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_RUN,
      S_RESULT
   } state_t;

   state_t r_state;
   state_t w_next;

   logic              r_done_d;
   logic              r_start;
   logic [31:0]       r_nonce_in;
   logic              r_resume;
   logic [ACK_W-1:0]  r_ack_cnt;
   logic              r_res_f;
   logic [31:0]       r_res_n;
   logic [CNT_W-1:0]  r_found_cnt;
   logic              r_err_ack;

   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_count;

   logic              w_done_rise;
   logic              w_ack_max;
   logic              w_full;
   logic              w_pop;
   logic              w_space;
   logic              w_job_ready;
   logic              w_busy;
   logic              w_accept;
   logic              w_launch;
   logic              w_ack_inc;
   logic              w_timeout;
   logic              w_capture;
   logic              w_push;
   logic              w_relaunch;

   assign w_done_rise = core_done & ~r_done_d;
   assign w_ack_max   = (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
   assign w_full      = (r_count == LW'(FIFO_DEPTH));
   assign w_pop       = (r_count != '0) & res_ready;
   // A pop in the same cycle frees the slot, so a stalled push may proceed.
   assign w_space     = ~w_full | w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:     if (job_valid) w_next = S_LAUNCH;
         S_LAUNCH:   w_next = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (!core_done)     w_next = S_RUN;
            else if (w_ack_max) w_next = S_IDLE;
         end
         S_RUN:      if (w_done_rise) w_next = S_RESULT;
         S_RESULT: begin
            if (!r_res_f)        w_next = S_IDLE;
            else if (w_space)    w_next = w_relaunch ? S_LAUNCH : S_IDLE;
         end
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_job_ready = 1'b0;
      w_busy      = 1'b1;
      w_accept    = 1'b0;
      w_launch    = 1'b0;
      w_ack_inc   = 1'b0;
      w_timeout   = 1'b0;
      w_capture   = 1'b0;
      w_push      = 1'b0;
      w_relaunch  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_job_ready = 1'b1;
            w_busy      = 1'b0;
            w_accept    = job_valid;
         end
         S_LAUNCH:   w_launch = 1'b1;
         S_WAIT_ACK: begin
            w_ack_inc = core_done & ~w_ack_max;
            w_timeout = core_done & w_ack_max;
         end
         S_RUN:      w_capture = w_done_rise;
         S_RESULT: begin
            w_push     = r_res_f & w_space;
            w_relaunch = r_res_f & w_space & r_resume & (r_res_n != '1);
         end
         default:    w_busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done_d    <= 1'b1;
         r_start     <= 1'b0;
         r_nonce_in  <= '0;
         r_resume    <= 1'b0;
         r_ack_cnt   <= '0;
         r_res_f     <= 1'b0;
         r_res_n     <= '0;
         r_found_cnt <= '0;
         r_err_ack   <= 1'b0;
      end else begin
         r_done_d <= core_done;
         if (w_accept) begin
            r_nonce_in <= job_nonce;
            r_resume   <= job_resume;
         end
         if (w_launch) begin
            r_start   <= ~r_start;
            r_ack_cnt <= '0;
         end
         if (w_ack_inc) r_ack_cnt <= r_ack_cnt + ACK_W'(1);
         if (w_timeout) r_err_ack <= 1'b1;
         if (w_capture) begin
            r_res_f <= core_nonce_found_flag;
            r_res_n <= core_nonce_out;
         end
         if (w_push && (r_found_cnt != '1)) r_found_cnt <= r_found_cnt + CNT_W'(1);
         if (w_relaunch) r_nonce_in <= r_res_n + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_res_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef BTC_COLLECTOR_ELAPSED_EN
   logic [31:0] r_elapsed;
   logic [31:0] r_res_cyc;
   logic [31:0] r_mem_cyc [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_elapsed <= '0;
         r_res_cyc <= '0;
      end else begin
         if (w_launch) begin
            r_elapsed <= '0;
         end else if (((r_state == S_WAIT_ACK) || (r_state == S_RUN)) && (r_elapsed != '1)) begin
            r_elapsed <= r_elapsed + 32'd1;
         end
         if (w_capture) r_res_cyc <= r_elapsed;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem_cyc[r_wr_ptr] <= r_res_cyc;
   end

   assign res_cycles = r_mem_cyc[r_rd_ptr];
`endif

   assign job_ready         = w_job_ready & ~rst;
   assign busy              = w_busy;
   assign core_start_a      = r_start;
   assign core_use_nonce_in = 1'b1;
   assign core_nonce_in     = r_nonce_in;
   assign res_valid         = (r_count != '0);
   assign res_nonce         = r_mem[r_rd_ptr];
   assign res_level         = r_count;
   assign found_count       = r_found_cnt;
   assign err_ack           = r_err_ack;

endmodule

// File: tb/tb_btc_result_collector.sv
// Bench for btc_result_collector: behavioural mining-core model, launch and
// result scoreboards, and one task per scenario.
module tb_btc_result_collector;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_nonce = '0;
   logic        job_resume = 1'b0;
   logic        core_start_a;
   logic        core_use_nonce_in;
   logic [31:0] core_nonce_in;
   logic        core_done = 1'b1;
   logic        core_nonce_found_flag = 1'b0;
   logic [31:0] core_nonce_out = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_nonce;
   logic [2:0]  res_level;
   logic        busy;
   logic [15:0] found_count;
   logic        err_ack;
`ifdef BTC_COLLECTOR_ELAPSED_EN
   logic [31:0] res_cycles;
`endif

   btc_result_collector #(
      .FIFO_DEPTH (4),
      .ACK_TIMEOUT(16),
      .CNT_W      (16)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .job_valid            (job_valid),
      .job_ready            (job_ready),
      .job_nonce            (job_nonce),
      .job_resume           (job_resume),
      .core_start_a         (core_start_a),
      .core_use_nonce_in    (core_use_nonce_in),
      .core_nonce_in        (core_nonce_in),
      .core_done            (core_done),
      .core_nonce_found_flag(core_nonce_found_flag),
      .core_nonce_out       (core_nonce_out),
      .res_valid            (res_valid),
      .res_ready            (res_ready),
      .res_nonce            (res_nonce),
      .res_level            (res_level),
      .busy                 (busy),
      .found_count          (found_count),
`ifdef BTC_COLLECTOR_ELAPSED_EN
      .res_cycles           (res_cycles),
`endif
      .err_ack              (err_ack)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_launch_q[$];
   bit   [32:0] script_q[$];

   // Core model: ~5 cycles to drop done after a start toggle, 8 cycles of search.
   int unsigned m_phase = 0;
   int unsigned m_cnt = 0;
   int unsigned m_launches = 0;
   bit          m_no_ack = 1'b0;
   logic        m_prev = 1'b0;
   logic [31:0] m_exp;
   bit   [32:0] m_res;

   always begin
      @(posedge clk);
      #2;
      if (rst) begin
         m_phase   = 0;
         m_cnt     = 0;
         core_done = 1'b1;
         m_prev    = core_start_a;
      end else begin
         if (core_start_a !== m_prev) begin
            m_prev = core_start_a;
            m_launches++;
            vectors++;
            if (exp_launch_q.size() == 0) begin
               errors++;
               $display("FAIL launch_nonce: unexpected launch with %h, none expected", core_nonce_in);
            end else begin
               m_exp = exp_launch_q.pop_front();
               if (core_nonce_in !== m_exp || core_use_nonce_in !== 1'b1) begin
                  errors++;
                  $display("FAIL launch_nonce: got %h use=%b, expected %h use=1",
                           core_nonce_in, core_use_nonce_in, m_exp);
               end
            end
            if (!m_no_ack) begin
               m_phase = 1;
               m_cnt   = 0;
            end
         end
         if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt == 5) begin
               core_done = 1'b0;
               m_phase   = 2;
               m_cnt     = 0;
            end
         end else if (m_phase == 2) begin
            m_cnt++;
            if (m_cnt == 8) begin
               if (script_q.size() != 0) m_res = script_q.pop_front();
               else                      m_res = {1'b0, 32'hDEAD_0000};
               core_nonce_found_flag = m_res[32];
               core_nonce_out        = m_res[31:0];
               core_done             = 1'b1;
               m_phase               = 0;
            end
         end
      end
   end

   logic [31:0] mon_exp;
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL fifo_pop: got %h, no entry expected", res_nonce);
         end else begin
            mon_exp = exp_q.pop_front();
            if (res_nonce !== mon_exp) begin
               errors++;
               $display("FAIL fifo_pop: got %h, expected %h", res_nonce, mon_exp);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic submit(input logic [31:0] n, input logic r);
      step();
      job_valid  = 1'b1;
      job_nonce  = n;
      job_resume = r;
      step();
      job_valid = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned max, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain(input int unsigned max, output bit ok);
      ok = 1'b0;
      step();
      res_ready = 1'b1;
      for (int unsigned i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy && !res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      @(negedge clk);
      vectors++;
      if ({job_ready, core_start_a, core_use_nonce_in, res_valid, busy, err_ack} !== 6'b001000 ||
          core_nonce_in !== 32'h0 || res_level !== 3'd0 || found_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b st=%b use=%b rv=%b busy=%b err=%b nin=%h lvl=%0d cnt=%0d, expected 0 0 1 0 0 0 0 0 0",
                  job_ready, core_start_a, core_use_nonce_in, res_valid, busy, err_ack,
                  core_nonce_in, res_level, found_count);
      end
      step();
      rst       = 1'b0;
      res_ready = 1'b1;
      repeat (2) step();
      res_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || res_level !== 3'd0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got rdy=%b busy=%b lvl=%0d rv=%b, expected 1 0 0 0",
                  job_ready, busy, res_level, res_valid);
      end
   endtask

   task automatic test_single_find();
      bit ok;
      script_q.push_back({1'b1, 32'h0000_1234});
      exp_q.push_back(32'h0000_1234);
      exp_launch_q.push_back(32'h0000_1000);
      submit(32'h0000_1000, 1'b0);
      wait_idle(200, ok);
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL single_idle: busy=%b after 200 cycles, expected 0", busy);
      end
      vectors++;
      if (found_count !== 16'd1 || job_ready !== 1'b1 || res_level !== 3'd1 ||
          res_valid !== 1'b1 || res_nonce !== 32'h0000_1234) begin
         errors++;
         $display("FAIL single_result: got cnt=%0d rdy=%b lvl=%0d rv=%b head=%h, expected 1 1 1 1 00001234",
                  found_count, job_ready, res_level, res_valid, res_nonce);
      end
      drain(50, ok);
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL single_drain: lvl=%0d, expected 0", res_level);
      end
   endtask

   task automatic test_resume();
      bit ok;
      script_q.push_back({1'b1, 32'h20});
      script_q.push_back({1'b1, 32'h30});
      exp_q.push_back(32'h20);
      exp_q.push_back(32'h30);
      exp_launch_q.push_back(32'h10);
      exp_launch_q.push_back(32'h21);
      exp_launch_q.push_back(32'h31);
      step();
      res_ready = 1'b1;
      submit(32'h10, 1'b1);
      wait_idle(400, ok);
      step();
      res_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (!ok || found_count !== 16'd3 || res_level !== 3'd0 || job_ready !== 1'b1) begin
         errors++;
         $display("FAIL resume_chain: got idle_ok=%b cnt=%0d lvl=%0d rdy=%b, expected 1 3 0 1",
                  ok, found_count, res_level, job_ready);
      end
   endtask

   task automatic test_max_nonce();
      bit ok;
      int unsigned l0;
      l0 = m_launches;
      script_q.push_back({1'b1, 32'hFFFF_FFFF});
      script_q.push_back({1'b1, 32'h0000_0077});
      exp_q.push_back(32'hFFFF_FFFF);
      exp_launch_q.push_back(32'h0000_0500);
      submit(32'h0000_0500, 1'b1);
      wait_idle(200, ok);
      repeat (10) @(negedge clk);
      vectors++;
      if (!ok || busy !== 1'b0 || found_count !== 16'd4 || (m_launches - l0) != 1 ||
          res_nonce !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL max_nonce: got idle_ok=%b busy=%b cnt=%0d launches=%0d head=%h, expected 1 0 4 1 ffffffff",
                  ok, busy, found_count, m_launches - l0, res_nonce);
      end
      script_q.delete();
      drain(50, ok);
   endtask

   task automatic test_fifo_full();
      bit ok;
      int unsigned l0;
      l0 = m_launches;
      exp_launch_q.push_back(32'h100);
      for (int unsigned k = 2; k <= 7; k++) begin
         script_q.push_back({1'b1, 32'(k) << 8});
         exp_q.push_back(32'(k) << 8);
         exp_launch_q.push_back((32'(k) << 8) + 32'd1);
      end
      submit(32'h100, 1'b1);
      ok = 1'b0;
      for (int unsigned i = 0; i < 400; i++) begin
         @(negedge clk);
         if (res_level == 3'd4) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (30) @(negedge clk);
      vectors++;
      if (!ok || res_level !== 3'd4 || busy !== 1'b1 || found_count !== 16'd8 ||
          (m_launches - l0) != 5 || res_nonce !== 32'h200) begin
         errors++;
         $display("FAIL fifo_stall: got ok=%b lvl=%0d busy=%b cnt=%0d launches=%0d head=%h, expected 1 4 1 8 5 00000200",
                  ok, res_level, busy, found_count, m_launches - l0, res_nonce);
      end
      step();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      step();
      @(negedge clk);
      vectors++;
      if (res_level !== 3'd4 || found_count !== 16'd9 || res_nonce !== 32'h300) begin
         errors++;
         $display("FAIL fifo_refill: got lvl=%0d cnt=%0d head=%h, expected 4 9 00000300",
                  res_level, found_count, res_nonce);
      end
      drain(600, ok);
      @(negedge clk);
      vectors++;
      if (!ok || found_count !== 16'd10 || (m_launches - l0) != 7) begin
         errors++;
         $display("FAIL fifo_finish: got ok=%b cnt=%0d launches=%0d, expected 1 10 7",
                  ok, found_count, m_launches - l0);
      end
   endtask

   task automatic test_ack_timeout();
      bit   found;
      logic prev;
      m_no_ack = 1'b1;
      exp_launch_q.push_back(32'h900);
      submit(32'h900, 1'b0);
      prev  = core_start_a;
      found = 1'b0;
      for (int unsigned i = 0; i < 10; i++) begin
         step();
         if (core_start_a !== prev) begin
            found = 1'b1;
            break;
         end
      end
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL ack_toggle: start line stayed %b, expected a toggle", core_start_a);
      end
      repeat (15) step();
      vectors++;
      if (err_ack !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ack_early: got err=%b busy=%b at 15 cycles, expected 0 1", err_ack, busy);
      end
      step();
      vectors++;
      if (err_ack !== 1'b1 || busy !== 1'b0 || job_ready !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout: got err=%b busy=%b rdy=%b at 16 cycles, expected 1 0 1",
                  err_ack, busy, job_ready);
      end
      m_no_ack = 1'b0;
      repeat (8) step();
      vectors++;
      if (err_ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_sticky: got err=%b, expected 1", err_ack);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      int unsigned l0;
      script_q.push_back({1'b1, 32'hABC});
      exp_q.push_back(32'hABC);
      exp_launch_q.push_back(32'hA00);
      submit(32'hA00, 1'b0);
      ok = 1'b0;
      for (int unsigned i = 0; i < 50; i++) begin
         @(negedge clk);
         if (core_done == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      l0 = m_launches;
      step();
      job_valid = 1'b1;
      job_nonce = 32'hDEAD;
      step();
      job_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (!ok || job_ready !== 1'b0 || busy !== 1'b1 || core_nonce_in !== 32'hA00) begin
         errors++;
         $display("FAIL busy_reject: got ok=%b rdy=%b busy=%b nin=%h, expected 1 0 1 00000a00",
                  ok, job_ready, busy, core_nonce_in);
      end
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      vectors++;
      if ({job_ready, core_start_a, core_use_nonce_in, res_valid, busy, err_ack} !== 6'b001000 ||
          core_nonce_in !== 32'h0 || res_level !== 3'd0 || found_count !== 16'h0 ||
          m_launches != l0) begin
         errors++;
         $display("FAIL midrun_reset: got rdy=%b st=%b use=%b rv=%b busy=%b err=%b nin=%h lvl=%0d cnt=%0d, expected 0 0 1 0 0 0 0 0 0",
                  job_ready, core_start_a, core_use_nonce_in, res_valid, busy, err_ack,
                  core_nonce_in, res_level, found_count);
      end
      step();
      rst = 1'b0;
      script_q.delete();
      exp_q.delete();
      script_q.push_back({1'b1, 32'hBEE});
      exp_q.push_back(32'hBEE);
      exp_launch_q.push_back(32'hB00);
      submit(32'hB00, 1'b0);
      wait_idle(200, ok);
      vectors++;
      if (!ok || found_count !== 16'd1 || res_nonce !== 32'hBEE || err_ack !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_job: got ok=%b cnt=%0d head=%h err=%b, expected 1 1 00000bee 0",
                  ok, found_count, res_nonce, err_ack);
      end
      drain(50, ok);
   endtask

   initial begin
      test_reset();
      test_single_find();
      test_resume();
      test_max_nonce();
      test_fifo_full();
      test_ack_timeout();
      test_reset_mid_run();
      repeat (4) step();
      vectors++;
      if (exp_q.size() != 0 || exp_launch_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d results and %0d launches outstanding, expected 0 0",
                  exp_q.size(), exp_launch_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
